// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder controller.
// The FSM encoding is visible to anything that imports the package.
package serial_adder_pkg;

  localparam int unsigned WidthDefault = 8;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  // One spare bit so the counter can represent WIDTH without wrapping.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/serial_fa_bit.sv
// Single-bit full adder built from two half adders and an OR.
// Purely combinational; the controller holds all state.
module serial_fa_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic ha0_sum;
  logic ha0_carry;
  logic ha1_carry;

  assign ha0_sum   = a ^ b;
  assign ha0_carry = a & b;

  assign sum       = ha0_sum ^ cin;
  assign ha1_carry = ha0_sum & cin;

  assign cout      = ha0_carry | ha1_carry;

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: accepts an operand pair, adds one bit per cycle LSB first,
// and presents sum/cout/ovf with a valid/ready handshake.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = WidthDefault
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int unsigned CntW = cnt_width(WIDTH);
  localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              carry_q, carry_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              cout_q, cout_d;
  logic              ovf_q, ovf_d;

  logic              fa_sum;
  logic              fa_cout;

  // Operands shift right each cycle, so bit 0 is always the pair in flight.
  serial_fa_bit u_fa (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d     = op_a;
          b_d     = op_b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = StRun;
        end
      end

      StRun: begin
        if (abort) begin
          // Abort wins over the final bit: no DONE entry, result cleared.
          sum_d   = '0;
          cout_d  = 1'b0;
          ovf_d   = 1'b0;
          state_d = StIdle;
        end else begin
          sum_d   = {fa_sum, sum_q[WIDTH-1:1]};
          a_d     = {1'b0, a_q[WIDTH-1:1]};
          b_d     = {1'b0, b_q[WIDTH-1:1]};
          carry_d = fa_cout;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == LastBit) begin
            cout_d  = fa_cout;
            // carry_q is the carry into the MSB at this point.
            ovf_d   = carry_q ^ fa_cout;
            state_d = StDone;
          end
        end
      end

      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign busy      = (state_q == StRun);
  assign out_valid = (state_q == StDone);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed self-checking bench for serial_adder_ctrl at WIDTH=8.
module tb_serial_adder_ctrl;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] op_a;
  logic [7:0] op_b;
  logic       cin;
  logic       abort;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] sum;
  logic       cout;
  logic       ovf;
  logic       busy;

  int errors = 0;
  int checks = 0;

  serial_adder_ctrl #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .cin       (cin),
    .abort     (abort),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Offer operands at a negedge; returns just after the acceptance edge.
  task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic c);
    @(negedge clk);
    op_a = a;
    op_b = b;
    cin = c;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Cycles from the acceptance edge until out_valid, bounded at 20.
  task automatic wait_out(output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1 n++;
    end while (!out_valid && n < 20);
  endtask

  task automatic handshake();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({in_ready, out_valid, busy} !== 3'b100) begin
      errors++;
      $display("FAIL reset_ctrl: got rdy/vld/busy=%b required 100", {in_ready, out_valid, busy});
    end
    checks++;
    if ({sum, cout, ovf} !== 10'h0) begin
      errors++;
      $display("FAIL reset_result: got sum=%h cout=%b ovf=%b required 00/0/0", sum, cout, ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_zero_latency();
    int n;
    @(negedge clk);
    op_a = 8'h00;
    op_b = 8'h00;
    cin = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    checks++;
    if ({in_ready, busy, out_valid} !== 3'b010) begin
      errors++;
      $display("FAIL run_state: got rdy/busy/vld=%b required 010", {in_ready, busy, out_valid});
    end
    wait_out(n);
    checks++;
    if (n !== 8) begin
      errors++;
      $display("FAIL latency: got %0d cycles required 8", n);
    end
    checks++;
    if ({sum, cout, ovf} !== 10'h0) begin
      errors++;
      $display("FAIL zero_add: got sum=%h cout=%b ovf=%b required 00/0/0", sum, cout, ovf);
    end
    handshake();
    checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      errors++;
      $display("FAIL zero_release: got rdy/vld=%b required 10", {in_ready, out_valid});
    end
  endtask

  task automatic test_vectors();
    logic [7:0] va [5] = '{8'hFF, 8'h7F, 8'hA5, 8'h80, 8'h12};
    logic [7:0] vb [5] = '{8'h01, 8'h01, 8'h5A, 8'h80, 8'h34};
    logic       vc [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [7:0] es [5] = '{8'h00, 8'h80, 8'h00, 8'h00, 8'h46};
    logic       ec [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic       eo [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    int n;
    for (int i = 0; i < 5; i++) begin
      start_op(va[i], vb[i], vc[i]);
      wait_out(n);
      checks++;
      if (n !== 8 || sum !== es[i] || cout !== ec[i] || ovf !== eo[i]) begin
        errors++;
        $display("FAIL vec%0d: got n=%0d sum=%h cout=%b ovf=%b required 8/%h/%b/%b",
                 i, n, sum, cout, ovf, es[i], ec[i], eo[i]);
      end
      handshake();
      checks++;
      if (in_ready !== 1'b1 || sum !== es[i]) begin
        errors++;
        $display("FAIL vec%0d_idle_hold: got rdy=%b sum=%h required 1/%h", i, in_ready, sum, es[i]);
      end
    end
  endtask

  task automatic test_hold_done();
    int n;
    start_op(8'h3C, 8'h0F, 1'b0);
    wait_out(n);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      op_a = 8'hA0 + 8'(i);
      op_b = 8'h55;
      abort = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if ({out_valid, in_ready, sum, cout, ovf} !== {2'b10, 8'h4B, 2'b00}) begin
        errors++;
        $display("FAIL done_hold%0d: got vld=%b rdy=%b sum=%h cout=%b ovf=%b required 1/0/4b/0/0",
                 i, out_valid, in_ready, sum, cout, ovf);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    abort = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    checks++;
    if ({in_ready, out_valid, sum} !== {2'b10, 8'h4B}) begin
      errors++;
      $display("FAIL done_release: got rdy=%b vld=%b sum=%h required 1/0/4b", in_ready, out_valid, sum);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({busy, in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL no_capture: got busy=%b rdy=%b required 0/1", busy, in_ready);
    end
  endtask

  task automatic test_async_reset();
    int n;
    start_op(8'h0F, 8'h01, 1'b0);
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, busy, sum, cout, ovf} !== {3'b100, 8'h00, 2'b00}) begin
      errors++;
      $display("FAIL async_reset: got rdy=%b vld=%b busy=%b sum=%h cout=%b ovf=%b required 1/0/0/00/0/0",
               in_ready, out_valid, busy, sum, cout, ovf);
    end
    #10;
    @(negedge clk);
    rst_n = 1'b1;
    start_op(8'h03, 8'h04, 1'b0);
    wait_out(n);
    checks++;
    if (n !== 8 || sum !== 8'h07 || cout !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_add: got n=%0d sum=%h cout=%b ovf=%b required 8/07/0/0", n, sum, cout, ovf);
    end
    handshake();
  endtask

  task automatic test_abort_final();
    int n;
    logic seen;
    start_op(8'h80, 8'h80, 1'b0);
    wait_out(n);
    handshake();
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    checks++;
    if ({sum, cout, ovf, in_ready} !== {8'h00, 3'b111}) begin
      errors++;
      $display("FAIL abort_idle: got sum=%h cout=%b ovf=%b rdy=%b required 00/1/1/1", sum, cout, ovf, in_ready);
    end
    start_op(8'h11, 8'h22, 1'b1);
    repeat (7) @(posedge clk);
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    checks++;
    if ({out_valid, in_ready, busy, sum, cout, ovf} !== {3'b010, 8'h00, 2'b00}) begin
      errors++;
      $display("FAIL abort_final: got vld=%b rdy=%b busy=%b sum=%h cout=%b ovf=%b required 0/1/0/00/0/0",
               out_valid, in_ready, busy, sum, cout, ovf);
    end
    seen = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1 seen = seen | out_valid;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_valid: got out_valid pulse=%b required 0", seen);
    end
  endtask

  task automatic test_back_to_back();
    int acc [$];
    int gaps_bad;
    out_ready = 1'b1;
    op_a = 8'h01;
    op_b = 8'h01;
    cin = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      if (in_ready) acc.push_back(k);
    end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 out_ready = 1'b0;
    checks++;
    if (acc.size() !== 4) begin
      errors++;
      $display("FAIL b2b_count: got %0d acceptances required 4", acc.size());
    end
    gaps_bad = 0;
    for (int i = 1; i < acc.size(); i++) begin
      if (acc[i] - acc[i-1] != 10) gaps_bad++;
    end
    checks++;
    if (gaps_bad !== 0 || acc.size() < 2) begin
      errors++;
      $display("FAIL b2b_spacing: got %0d gaps not equal to 10 (n=%0d) required 0", gaps_bad, acc.size());
    end
    checks++;
    if ({in_ready, sum, cout, ovf} !== {1'b1, 8'h02, 2'b00}) begin
      errors++;
      $display("FAIL b2b_result: got rdy=%b sum=%h cout=%b ovf=%b required 1/02/0/0", in_ready, sum, cout, ovf);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    op_a = '0;
    op_b = '0;
    cin = 1'b0;
    abort = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_zero_latency();
    test_vectors();
    test_hold_done();
    test_async_reset();
    test_abort_final();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
